// File: rtl/tlb_array_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : cpuDefine
//  Purpose  : Shared TLB types, sizes, INVTLB opcodes and page-match helper.
//  Revision : 1.0  initial release
// ============================================================================
package cpuDefine;

  localparam int TLBNUMSIZE = 4;
  localparam int TLBNUM     = 2 ** TLBNUMSIZE;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  // INVTLB operation codes; 7..31 are no-ops here
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GASID_VA   = 5'd6;

  typedef struct packed {
    logic [19:0] ppn;
    logic [1:0]  mat;
    logic [1:0]  plv;
    logic        d;
    logic        v;
  } PhytranItem;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
    PhytranItem  p0;
    PhytranItem  p1;
  } TlbEntry;

  // VPPN compare at the granularity implied by the page size; unsupported
  // page sizes never match.
  function automatic logic vppn_match(input logic [5:0]  ps,
                                      input logic [18:0] ent_vppn,
                                      input logic [18:0] key_vppn);
    logic m;
    m = 1'b0;
    if (ps == PS_4K) begin
      m = (ent_vppn == key_vppn);
    end else if (ps == PS_2M) begin
      m = (ent_vppn[18:9] == key_vppn[18:9]);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_entry_match.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_entry_match
//  Purpose  : Combinational compare of one TLB entry against a lookup key.
//             Produces the hit bit and the odd/even page select.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_entry_match
  import cpuDefine::*;
(
  input  TlbEntry     entry_i,
  input  logic [18:0] vppn_i,
  input  logic        va12_i,
  input  logic        va21_i,
  input  logic [9:0]  asid_i,
  output logic        hit_o,
  output logic        odd_o
);

  assign hit_o = entry_i.e
               && (entry_i.g || (entry_i.asid == asid_i))
               && vppn_match(entry_i.ps, entry_i.vppn, vppn_i);

  // Only meaningful on a hit, where PS is either 12 or 21
  assign odd_o = (entry_i.ps == PS_4K) ? va12_i : va21_i;

endmodule
`default_nettype wire

// File: rtl/tlb_array.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_array
//  Purpose  : TLB storage with registered fetch/data lookups, TLBRD reads,
//             TLBWR/TLBFILL writes, INVTLB invalidation and fill victim.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_array
  import cpuDefine::*;
(
  input  logic                  clk,
  input  logic                  reset,
  // fetch lookup
  input  logic                  s0_req,
  input  logic [18:0]           s0_vppn,
  input  logic                  s0_va12,
  input  logic                  s0_va21,
  input  logic [9:0]            s0_asid,
  output logic                  s0_valid,
  output logic                  s0_found,
  output logic [TLBNUMSIZE-1:0] s0_index,
  output logic [5:0]            s0_ps,
  output PhytranItem            s0_phytran,
  // data / TLBSRCH lookup
  input  logic                  s1_req,
  input  logic [18:0]           s1_vppn,
  input  logic                  s1_va12,
  input  logic                  s1_va21,
  input  logic [9:0]            s1_asid,
  output logic                  s1e,
  output logic                  s1_found,
  output logic                  s1_ne,
  output logic [TLBNUMSIZE-1:0] s1_index,
  output logic [5:0]            s1_ps,
  output PhytranItem            s1_phytran,
  // TLBRD
  input  logic                  r_req,
  input  logic [TLBNUMSIZE-1:0] r_index,
  output logic                  re,
  output logic [5:0]            r_ps,
  output logic [9:0]            r_asid,
  output logic                  r_ne,
  output logic                  r_g,
  output logic [18:0]           r_vppn,
  output PhytranItem            r_phytran0,
  output PhytranItem            r_phytran1,
  // TLBWR / TLBFILL
  input  logic                  we,
  input  logic [TLBNUMSIZE-1:0] w_index,
  input  logic [5:0]            w_ps,
  input  logic                  w_ne,
  input  logic [9:0]            w_asid,
  input  logic [18:0]           w_vppn,
  input  logic                  w_g,
  input  PhytranItem            w_phytran0,
  input  PhytranItem            w_phytran1,
  output logic [TLBNUMSIZE-1:0] fill_index,
  // INVTLB
  input  logic                  inv_valid,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            f_asid,
  input  logic [18:0]           f_va
);

  TlbEntry               ents_q [TLBNUM];
  logic [TLBNUM-1:0]     s0_hit, s0_odd, s1_hit, s1_odd, inv_hit;

  logic                  s0_found_d, s1_found_d;
  logic [TLBNUMSIZE-1:0] s0_index_d, s1_index_d;
  logic [5:0]            s0_ps_d, s1_ps_d;
  PhytranItem            s0_phytran_d, s1_phytran_d;
  TlbEntry               rd_ent, w_entry_d;

  logic                  s0_valid_q, s0_found_q, s1e_q, s1_found_q, re_q, r_ne_q, r_g_q;
  logic [TLBNUMSIZE-1:0] s0_index_q, s1_index_q, fill_q;
  logic [5:0]            s0_ps_q, s1_ps_q, r_ps_q;
  logic [9:0]            r_asid_q;
  logic [18:0]           r_vppn_q;
  PhytranItem            s0_phytran_q, s1_phytran_q, r_p0_q, r_p1_q;

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_match
    tlb_entry_match u_s0 (
      .entry_i (ents_q[gi]), .vppn_i (s0_vppn), .va12_i (s0_va12), .va21_i (s0_va21),
      .asid_i  (s0_asid),    .hit_o  (s0_hit[gi]), .odd_o (s0_odd[gi])
    );
    tlb_entry_match u_s1 (
      .entry_i (ents_q[gi]), .vppn_i (s1_vppn), .va12_i (s1_va12), .va21_i (s1_va21),
      .asid_i  (s1_asid),    .hit_o  (s1_hit[gi]), .odd_o (s1_odd[gi])
    );
  end

  // Lowest-index hit; MSB of the result is the found flag
  function automatic logic [TLBNUMSIZE:0] first_hit(input logic [TLBNUM-1:0] hits);
    logic [TLBNUMSIZE:0] res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hits[i]) res = {1'b1, TLBNUMSIZE'(i)};
    end
    return res;
  endfunction

  // Priority-encode both lookup ports and select the page; misses return zeros
  always_comb begin
    {s0_found_d, s0_index_d} = first_hit(s0_hit);
    {s1_found_d, s1_index_d} = first_hit(s1_hit);
    s0_ps_d      = '0;
    s0_phytran_d = '0;
    s1_ps_d      = '0;
    s1_phytran_d = '0;
    if (s0_found_d) begin
      s0_ps_d      = ents_q[s0_index_d].ps;
      s0_phytran_d = s0_odd[s0_index_d] ? ents_q[s0_index_d].p1 : ents_q[s0_index_d].p0;
    end
    if (s1_found_d) begin
      s1_ps_d      = ents_q[s1_index_d].ps;
      s1_phytran_d = s1_odd[s1_index_d] ? ents_q[s1_index_d].p1 : ents_q[s1_index_d].p0;
    end
  end

  // INVTLB selection per entry, decoded from the operation code
  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_hit[i] = 1'b1;
        INV_G1:             inv_hit[i] = ents_q[i].g;
        INV_G0:             inv_hit[i] = ~ents_q[i].g;
        INV_G0_ASID:        inv_hit[i] = ~ents_q[i].g && (ents_q[i].asid == f_asid);
        INV_G0_ASID_VA:     inv_hit[i] = ~ents_q[i].g && (ents_q[i].asid == f_asid)
                                         && vppn_match(ents_q[i].ps, ents_q[i].vppn, f_va);
        INV_GASID_VA:       inv_hit[i] = (ents_q[i].g || (ents_q[i].asid == f_asid))
                                         && vppn_match(ents_q[i].ps, ents_q[i].vppn, f_va);
        default:            inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Read port source and the entry image to be written
  always_comb begin
    rd_ent    = ents_q[r_index];
    w_entry_d = '{e: ~w_ne, asid: w_asid, g: w_g, ps: w_ps, vppn: w_vppn,
                  p0: w_phytran0, p1: w_phytran1};
  end

  // Entry array: invalidation first, then the write so a same-cycle write wins
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) ents_q[i].e <= 1'b0;
    end else begin
      if (inv_valid) begin
        for (int i = 0; i < TLBNUM; i++) begin
          if (inv_hit[i]) ents_q[i].e <= 1'b0;
        end
      end
      if (we) ents_q[w_index] <= w_entry_d;
    end
  end

  // Registered lookup/read results and the free-running fill victim counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q <= 1'b0; s0_found_q <= 1'b0; s0_index_q <= '0; s0_ps_q <= '0; s0_phytran_q <= '0;
      s1e_q      <= 1'b0; s1_found_q <= 1'b0; s1_index_q <= '0; s1_ps_q <= '0; s1_phytran_q <= '0;
      re_q       <= 1'b0; r_ne_q <= 1'b0; r_g_q <= 1'b0; r_ps_q <= '0; r_asid_q <= '0;
      r_vppn_q   <= '0;   r_p0_q <= '0;   r_p1_q <= '0;
      fill_q     <= '0;
    end else begin
      s0_valid_q <= s0_req;
      s1e_q      <= s1_req;
      re_q       <= r_req;
      fill_q     <= fill_q + 1'b1;
      if (s0_req) begin
        s0_found_q <= s0_found_d; s0_index_q <= s0_index_d;
        s0_ps_q    <= s0_ps_d;    s0_phytran_q <= s0_phytran_d;
      end
      if (s1_req) begin
        s1_found_q <= s1_found_d; s1_index_q <= s1_index_d;
        s1_ps_q    <= s1_ps_d;    s1_phytran_q <= s1_phytran_d;
      end
      if (r_req) begin
        r_ne_q   <= ~rd_ent.e;
        r_g_q    <= rd_ent.e & rd_ent.g;
        r_ps_q   <= rd_ent.e ? rd_ent.ps   : '0;
        r_asid_q <= rd_ent.e ? rd_ent.asid : '0;
        r_vppn_q <= rd_ent.e ? rd_ent.vppn : '0;
        r_p0_q   <= rd_ent.e ? rd_ent.p0   : '0;
        r_p1_q   <= rd_ent.e ? rd_ent.p1   : '0;
      end
    end
  end

  assign s0_valid   = s0_valid_q;
  assign s0_found   = s0_found_q;
  assign s0_index   = s0_index_q;
  assign s0_ps      = s0_ps_q;
  assign s0_phytran = s0_phytran_q;
  assign s1e        = s1e_q;
  assign s1_found   = s1_found_q;
  assign s1_ne      = ~s1_found_q;
  assign s1_index   = s1_index_q;
  assign s1_ps      = s1_ps_q;
  assign s1_phytran = s1_phytran_q;
  assign re         = re_q;
  assign r_ps       = r_ps_q;
  assign r_asid     = r_asid_q;
  assign r_ne       = r_ne_q;
  assign r_g        = r_g_q;
  assign r_vppn     = r_vppn_q;
  assign r_phytran0 = r_p0_q;
  assign r_phytran1 = r_p1_q;
  assign fill_index = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlb_array
//  Purpose  : Self-checking bench for tlb_array against an array-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlb_array;
  import cpuDefine::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req, s0_va12, s0_va21, s0_valid, s0_found;
  logic [18:0] s0_vppn;
  logic [9:0]  s0_asid;
  logic [3:0]  s0_index;
  logic [5:0]  s0_ps;
  PhytranItem  s0_phytran;
  logic        s1_req, s1_va12, s1_va21, s1e, s1_found, s1_ne;
  logic [18:0] s1_vppn;
  logic [9:0]  s1_asid;
  logic [3:0]  s1_index;
  logic [5:0]  s1_ps;
  PhytranItem  s1_phytran;
  logic        r_req, re, r_ne, r_g;
  logic [3:0]  r_index;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [18:0] r_vppn;
  PhytranItem  r_phytran0, r_phytran1;
  logic        we, w_ne, w_g;
  logic [3:0]  w_index, fill_index;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [18:0] w_vppn;
  PhytranItem  w_phytran0, w_phytran1;
  logic        inv_valid;
  logic [4:0]  inv_op;
  logic [9:0]  f_asid;
  logic [18:0] f_va;

  int errors = 0;
  int checks = 0;

  tlb_array dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va12(s0_va12), .s0_va21(s0_va21), .s0_asid(s0_asid),
    .s0_valid(s0_valid), .s0_found(s0_found), .s0_index(s0_index), .s0_ps(s0_ps), .s0_phytran(s0_phytran),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va12(s1_va12), .s1_va21(s1_va21), .s1_asid(s1_asid),
    .s1e(s1e), .s1_found(s1_found), .s1_ne(s1_ne), .s1_index(s1_index), .s1_ps(s1_ps), .s1_phytran(s1_phytran),
    .r_req(r_req), .r_index(r_index), .re(re), .r_ps(r_ps), .r_asid(r_asid), .r_ne(r_ne), .r_g(r_g),
    .r_vppn(r_vppn), .r_phytran0(r_phytran0), .r_phytran1(r_phytran1),
    .we(we), .w_index(w_index), .w_ps(w_ps), .w_ne(w_ne), .w_asid(w_asid), .w_vppn(w_vppn), .w_g(w_g),
    .w_phytran0(w_phytran0), .w_phytran1(w_phytran1), .fill_index(fill_index),
    .inv_valid(inv_valid), .inv_op(inv_op), .f_asid(f_asid), .f_va(f_va)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit        m_e    [16];
  bit [9:0]  m_asid [16];
  bit        m_g    [16];
  bit [5:0]  m_ps   [16];
  bit [18:0] m_vppn [16];
  bit [25:0] m_p0   [16];
  bit [25:0] m_p1   [16];
  int        m_fill = 0;

  function automatic bit page_hit(bit [5:0] ps, bit [18:0] ev, bit [18:0] k);
    if (ps == 6'd12) return ev == k;
    if (ps == 6'd21) return (ev / 512) == (k / 512);
    return 1'b0;
  endfunction

  // {found, index, ps, phytran}
  function automatic bit [36:0] m_lookup(bit [18:0] vppn, bit va12, bit va21, bit [9:0] asid);
    for (int i = 0; i < 16; i++) begin
      if (m_e[i] && (m_g[i] || m_asid[i] == asid) && page_hit(m_ps[i], m_vppn[i], vppn))
        return {1'b1, 4'(i), m_ps[i], ((m_ps[i] == 6'd12 ? va12 : va21) ? m_p1[i] : m_p0[i])};
    end
    return '0;
  endfunction

  // {ne, g, ps, asid, vppn, p0, p1}
  function automatic bit [88:0] m_read(bit [3:0] idx);
    if (!m_e[idx]) return {1'b1, 88'd0};
    return {1'b0, m_g[idx], m_ps[idx], m_asid[idx], m_vppn[idx], m_p0[idx], m_p1[idx]};
  endfunction

  function automatic void m_inv(bit [4:0] op, bit [9:0] asid, bit [18:0] va);
    bit am, vm, kill;
    for (int i = 0; i < 16; i++) begin
      am = (m_asid[i] == asid);
      vm = page_hit(m_ps[i], m_vppn[i], va);
      case (op)
        5'd0, 5'd1: kill = 1'b1;
        5'd2:       kill = m_g[i];
        5'd3:       kill = !m_g[i];
        5'd4:       kill = !m_g[i] && am;
        5'd5:       kill = !m_g[i] && am && vm;
        5'd6:       kill = (m_g[i] || am) && vm;
        default:    kill = 1'b0;
      endcase
      if (kill) m_e[i] = 1'b0;
    end
  endfunction

  // Apply this cycle's driven INVTLB and write to the model (INVTLB first)
  task automatic model_edge();
    if (inv_valid) m_inv(inv_op, f_asid, f_va);
    if (we) begin
      m_e[w_index] = !w_ne;   m_asid[w_index] = w_asid; m_g[w_index] = w_g;
      m_ps[w_index] = w_ps;   m_vppn[w_index] = w_vppn;
      m_p0[w_index] = w_phytran0; m_p1[w_index] = w_phytran1;
    end
    if (reset) for (int i = 0; i < 16; i++) m_e[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_fill = reset ? 0 : (m_fill + 1) % 16;
    #1;
  endtask

  task automatic idle();
    s0_req = 0; s1_req = 0; r_req = 0; we = 0; inv_valid = 0; reset = 0;
  endtask

  task automatic drive_write(bit [3:0] idx, bit [5:0] ps, bit [9:0] asid, bit [18:0] vppn,
                             bit g, bit [25:0] p0, bit [25:0] p1);
    we = 1; w_index = idx; w_ps = ps; w_ne = 0; w_asid = asid; w_vppn = vppn; w_g = g;
    w_phytran0 = p0; w_phytran1 = p1;
  endtask

  task automatic drive_s1(bit [18:0] vppn, bit va12, bit va21, bit [9:0] asid);
    s1_req = 1; s1_vppn = vppn; s1_va12 = va12; s1_va21 = va21; s1_asid = asid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit [88:0] exp_r;
    idle(); reset = 1; s0_req = 1; s1_req = 1; r_req = 1; r_index = 0;
    model_edge(); tick();
    if ({s0_valid, s1e, re, s0_found, s1_found, s0_index, s1_index, fill_index} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b required 0",
                         {s0_valid, s1e, re, s0_found, s1_found, s0_index, s1_index, fill_index});
    end
    checks++;
    idle();
    for (int i = 0; i < 16; i++) begin
      r_req = 1; r_index = 4'(i); exp_r = m_read(4'(i));
      tick();
      if ({re, r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1} !== {1'b1, exp_r}
          || r_ne !== 1'b1) begin
        errors++; $display("FAIL reset_read%0d: got %h required %h", i,
                           {re, r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1}, {1'b1, exp_r});
      end
      checks++;
    end
    idle(); tick();
  endtask

  task automatic test_fill();
    idle(); reset = 1; model_edge(); tick(); idle();
    if (fill_index !== 4'd0) begin
      errors++; $display("FAIL fill_reset: got %0d required 0", fill_index);
    end
    checks++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (fill_index !== 4'(i % 16) || fill_index !== 4'(m_fill)) begin
        errors++; $display("FAIL fill_step%0d: got %0d required %0d", i, fill_index, i % 16);
      end
      checks++;
    end
  endtask

  task automatic test_basic_hit();
    bit [36:0] e;
    idle(); drive_write(4'd3, 6'd12, 10'd5, 19'h12345, 1'b0, {20'h11223, 6'd3}, {20'hABCDE, 6'd3});
    model_edge(); tick(); idle();
    drive_s1(19'h12345, 1'b1, 1'b0, 10'd5); e = m_lookup(s1_vppn, s1_va12, s1_va21, s1_asid);
    tick(); idle();
    if ({s1e, s1_found, s1_ne, s1_index, s1_ps, s1_phytran} !== {1'b1, e[36], ~e[36], e[35:0]}
        || s1_index !== 4'd3 || s1_phytran.ppn !== 20'hABCDE) begin
      errors++; $display("FAIL basic_hit: got %h required %h",
                         {s1e, s1_found, s1_ne, s1_index, s1_ps, s1_phytran}, {1'b1, e[36], ~e[36], e[35:0]});
    end
    checks++;
    drive_s1(19'h12345, 1'b1, 1'b0, 10'd6);
    tick(); idle();
    if ({s1e, s1_found, s1_ne, s1_index, s1_ps, s1_phytran} !== {3'b101, 36'd0}) begin
      errors++; $display("FAIL basic_asid_miss: got %h required %h",
                         {s1e, s1_found, s1_ne, s1_index, s1_ps, s1_phytran}, {3'b101, 36'd0});
    end
    checks++;
  endtask

  task automatic test_ps21();
    idle(); drive_write(4'd7, 6'd21, 10'd5, 19'h12200, 1'b0, {20'h11111, 6'd1}, {20'h22222, 6'd2});
    model_edge(); tick(); idle();
    drive_s1(19'h121FF, 1'b0, 1'b0, 10'd5);
    tick(); idle();
    if (s1_found !== 1'b0 || s1_ne !== 1'b1 || s1e !== 1'b1) begin
      errors++; $display("FAIL ps21_miss: got found=%b ne=%b required found=0 ne=1", s1_found, s1_ne);
    end
    checks++;
    drive_s1(19'h12300, 1'b1, 1'b0, 10'd5);
    tick(); idle();
    if ({s1_found, s1_index, s1_ps, s1_phytran} !== {1'b1, 4'd7, 6'd21, 20'h11111, 6'd1}) begin
      errors++; $display("FAIL ps21_hit: got %h required %h",
                         {s1_found, s1_index, s1_ps, s1_phytran}, {1'b1, 4'd7, 6'd21, 20'h11111, 6'd1});
    end
    checks++;
  endtask

  task automatic test_priority();
    idle(); drive_write(4'd9, 6'd12, 10'd5, 19'h00ABC, 1'b0, {20'h99999, 6'd0}, 26'd0);
    model_edge(); tick(); idle();
    drive_write(4'd2, 6'd12, 10'h3FF, 19'h00ABC, 1'b1, {20'h22222, 6'd0}, 26'd0);
    model_edge(); tick(); idle();
    drive_s1(19'h00ABC, 1'b0, 1'b0, 10'd5);
    s0_req = 1; s0_vppn = 19'h00ABC; s0_va12 = 0; s0_va21 = 0; s0_asid = 10'd5;
    tick(); idle();
    if (s1_index !== 4'd2 || s1_found !== 1'b1 || s1_phytran.ppn !== 20'h22222) begin
      errors++; $display("FAIL prio_s1: got idx=%0d found=%b required idx=2 found=1", s1_index, s1_found);
    end
    checks++;
    if (s0_valid !== 1'b1 || s0_index !== 4'd2 || s0_found !== 1'b1) begin
      errors++; $display("FAIL prio_s0: got valid=%b idx=%0d required valid=1 idx=2", s0_valid, s0_index);
    end
    checks++;
    inv_valid = 1; inv_op = 5'd2; f_asid = 0; f_va = 0;
    model_edge(); tick(); idle();
    drive_s1(19'h00ABC, 1'b0, 1'b0, 10'd5);
    tick(); idle();
    if (s1_index !== 4'd9 || s1_found !== 1'b1 || s1_phytran.ppn !== 20'h99999) begin
      errors++; $display("FAIL prio_after_inv: got idx=%0d found=%b required idx=9 found=1", s1_index, s1_found);
    end
    checks++;
  endtask

  task automatic test_inv_asid();
    bit [88:0] exp_r;
    idle(); drive_write(4'd10, 6'd12, 10'd6, 19'h00AAA, 1'b0, 26'h1234, 26'h5678);
    model_edge(); tick(); idle();
    drive_write(4'd11, 6'd12, 10'd5, 19'h00BBB, 1'b1, 26'h4321, 26'h8765);
    model_edge(); tick(); idle();
    inv_valid = 1; inv_op = 5'd4; f_asid = 10'd5; f_va = 0;
    model_edge(); tick(); idle();
    for (int i = 0; i < 16; i++) begin
      r_req = 1; r_index = 4'(i); exp_r = m_read(4'(i));
      tick();
      if ({re, r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1} !== {1'b1, exp_r}) begin
        errors++; $display("FAIL inv4_read%0d: got %h required %h", i,
                           {re, r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1}, {1'b1, exp_r});
      end
      checks++;
      if ((i == 3 || i == 9) && {r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1} !== {1'b1, 88'd0}) begin
        errors++; $display("FAIL inv4_cleared%0d: got ne=%b asid=%0d required ne=1 and zeros", i, r_ne, r_asid);
      end
      if ((i == 10 || i == 11) && r_ne !== 1'b0) begin
        errors++; $display("FAIL inv4_kept%0d: got ne=%b required 0", i, r_ne);
      end
      if (i == 3 || i == 9 || i == 10 || i == 11) checks++;
    end
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    drive_write(4'd4, 6'd12, 10'd1, 19'h00444, 1'b0, {20'h44440, 6'd0}, 26'd0);
    drive_s1(19'h00444, 1'b0, 1'b0, 10'd1);
    model_edge(); tick(); idle();
    if (s1_found !== 1'b0 || s1e !== 1'b1) begin
      errors++; $display("FAIL same_write_lookup_old: got found=%b required 0", s1_found);
    end
    checks++;
    drive_s1(19'h00444, 1'b0, 1'b0, 10'd1);
    tick(); idle();
    if (s1_found !== 1'b1 || s1_index !== 4'd4) begin
      errors++; $display("FAIL same_write_lookup_new: got found=%b idx=%0d required 1/4", s1_found, s1_index);
    end
    checks++;
    drive_write(4'd4, 6'd12, 10'd1, 19'h00444, 1'b0, {20'h44441, 6'd0}, 26'd0);
    inv_valid = 1; inv_op = 5'd0; f_asid = 0; f_va = 0;
    model_edge(); tick(); idle();
    r_req = 1; r_index = 4'd4;
    drive_s1(19'h00444, 1'b0, 1'b0, 10'd1);
    inv_valid = 1; inv_op = 5'd1;
    model_edge(); tick(); idle();
    if (r_ne !== 1'b0 || re !== 1'b1 || r_phytran0.ppn !== 20'h44441) begin
      errors++; $display("FAIL write_beats_inv: got ne=%b ppn=%h required ne=0 ppn=44441", r_ne, r_phytran0.ppn);
    end
    checks++;
    if (s1_found !== 1'b1 || s1_index !== 4'd4) begin
      errors++; $display("FAIL inv_lookup_old: got found=%b idx=%0d required 1/4", s1_found, s1_index);
    end
    checks++;
    drive_s1(19'h00444, 1'b0, 1'b0, 10'd1);
    tick(); idle();
    if (s1_found !== 1'b0) begin
      errors++; $display("FAIL inv_lookup_new: got found=%b required 0", s1_found);
    end
    checks++;
  endtask

  function automatic bit [18:0] rand_vppn();
    return {8'h12, 2'($urandom_range(0, 3)), 9'($urandom_range(0, 3))};
  endfunction

  task automatic test_random();
    bit [36:0] e0, e1;
    bit [88:0] er;
    bit        x0, x1, xr;
    int        sel;
    for (int n = 0; n < 400; n++) begin
      idle();
      s0_req = 1'($urandom_range(0, 1)); s0_vppn = rand_vppn(); s0_asid = 10'($urandom_range(0, 3));
      s0_va12 = 1'($urandom_range(0, 1)); s0_va21 = 1'($urandom_range(0, 1));
      s1_req = 1'($urandom_range(0, 1)); s1_vppn = rand_vppn(); s1_asid = 10'($urandom_range(0, 3));
      s1_va12 = 1'($urandom_range(0, 1)); s1_va21 = 1'($urandom_range(0, 1));
      r_req = 1'($urandom_range(0, 1)); r_index = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 4);
        we = 1; w_index = 4'($urandom_range(0, 15)); w_ne = ($urandom_range(0, 4) == 0);
        w_ps = (sel < 2) ? 6'd12 : (sel < 4) ? 6'd21 : 6'($urandom_range(0, 63));
        w_asid = 10'($urandom_range(0, 3)); w_vppn = rand_vppn(); w_g = ($urandom_range(0, 3) == 0);
        w_phytran0 = 26'($urandom); w_phytran1 = 26'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        inv_valid = 1; sel = $urandom_range(0, 8);
        inv_op = (sel == 8) ? 5'd31 : 5'(sel);
        f_asid = 10'($urandom_range(0, 3)); f_va = rand_vppn();
      end
      x0 = s0_req; x1 = s1_req; xr = r_req;
      e0 = m_lookup(s0_vppn, s0_va12, s0_va21, s0_asid);
      e1 = m_lookup(s1_vppn, s1_va12, s1_va21, s1_asid);
      er = m_read(r_index);
      model_edge(); tick();
      if ({s0_valid, s1e, re} !== {x0, x1, xr}) begin
        errors++; $display("FAIL rnd_valid%0d: got %b required %b", n, {s0_valid, s1e, re}, {x0, x1, xr});
      end
      checks++;
      if (x0 && {s0_found, s0_index, s0_ps, s0_phytran} !== e0) begin
        errors++; $display("FAIL rnd_s0_%0d: got %h required %h", n, {s0_found, s0_index, s0_ps, s0_phytran}, e0);
      end
      if (x1 && {s1_found, s1_ne, s1_index, s1_ps, s1_phytran} !== {e1[36], ~e1[36], e1[35:0]}) begin
        errors++; $display("FAIL rnd_s1_%0d: got %h required %h", n,
                           {s1_found, s1_ne, s1_index, s1_ps, s1_phytran}, {e1[36], ~e1[36], e1[35:0]});
      end
      if (xr && {r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1} !== er) begin
        errors++; $display("FAIL rnd_read%0d: got %h required %h", n,
                           {r_ne, r_g, r_ps, r_asid, r_vppn, r_phytran0, r_phytran1}, er);
      end
      checks += int'(x0) + int'(x1) + int'(xr);
      if (fill_index !== 4'(m_fill)) begin
        errors++; $display("FAIL rnd_fill%0d: got %0d required %0d", n, fill_index, m_fill);
      end
      checks++;
    end
    idle();
  endtask

  initial begin
    idle(); reset = 1;
    s0_vppn = 0; s0_va12 = 0; s0_va21 = 0; s0_asid = 0;
    s1_vppn = 0; s1_va12 = 0; s1_va21 = 0; s1_asid = 0;
    r_index = 0; w_index = 0; w_ps = 0; w_ne = 0; w_asid = 0; w_vppn = 0; w_g = 0;
    w_phytran0 = '0; w_phytran1 = '0; inv_op = 0; f_asid = 0; f_va = 0;
    model_edge(); tick(); tick();
    test_reset();
    test_fill();
    test_basic_hit();
    test_ps21();
    test_priority();
    test_inv_asid();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
